// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: CP0 Status/Cause/EPC/ExcCount with trap entry, ERET return and MTC0/MFC0 access.
// Redirect and flush are registered and asserted for exactly the one cycle spent in TRAP or RETURN.
module cp0_exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter logic [1:0]  STATUS_RST = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [31:0] cause_in,
    input  logic [31:0] epc_in,
    input  logic        eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        exl
);
    typedef enum logic [1:0] {RUN, TRAP, HANDLER, RETURN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  status_q, status_d;
    logic [4:0]  code_q, code_d;
    logic [2:0]  flags_q, flags_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pc_redirect_q, pc_redirect_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        active, take, first, ret, mtc0;
    logic [4:0]  exc_code;
    logic        unused_cause;

    assign unused_cause = ^cause_in[31:3];

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Exception beats ERET when both arrive in HANDLER.
    always_comb begin
        state_d = (state_q == TRAP)                 ? HANDLER :
                  (state_q == RETURN)               ? RUN     :
                  exception                         ? TRAP    :
                  (state_q == HANDLER && eret)      ? RETURN  : state_q;
    end

    always_comb begin
        active   = (state_q == RUN) || (state_q == HANDLER);
        take     = exception && active;
        first    = exception && (state_q == RUN);
        ret      = eret && !exception && (state_q == HANDLER);
        mtc0     = cp0_we && active;
        exc_code = (cause_in[0] || cause_in[1]) ? 5'd10 : cause_in[2] ? 5'd12 : 5'd0;
        status_d = first ? {1'b1, status_q[0]} :
                   ret   ? {1'b0, status_q[0]} :
                   (mtc0 && cp0_waddr == 5'd12) ? cp0_wdata[1:0] : status_q;
        epc_d    = first ? epc_in : (mtc0 && cp0_waddr == 5'd14) ? cp0_wdata : epc_q;
        code_d   = take ? exc_code : code_q;
        flags_d  = take ? cause_in[2:0] : flags_q;
        cnt_d    = (take && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_comb begin
        pc_redirect_d = (state_d == TRAP) || (state_d == RETURN);
        flush_d       = pc_redirect_d;
        redirect_pc_d = (state_d == TRAP)   ? EXC_VECTOR :
                        (state_d == RETURN) ? epc_d      : redirect_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q      <= STATUS_RST;
            code_q        <= '0;
            flags_q       <= '0;
            epc_q         <= '0;
            cnt_q         <= '0;
            pc_redirect_q <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            status_q      <= status_d;
            code_q        <= code_d;
            flags_q       <= flags_d;
            epc_q         <= epc_d;
            cnt_q         <= cnt_d;
            pc_redirect_q <= pc_redirect_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        cp0_rdata = (cp0_raddr == 5'd12) ? {30'd0, status_q} :
                    (cp0_raddr == 5'd13) ? {21'd0, flags_q, 1'b0, code_q, 2'b00} :
                    (cp0_raddr == 5'd14) ? epc_q :
                    (cp0_raddr == 5'd9)  ? {24'd0, cnt_q} : 32'd0;
    end

    assign pc_redirect = pc_redirect_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign exl         = status_q[1];
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb_cp0_exception_ctrl: directed checks of trap entry, nesting, ERET, MTC0/MFC0 and reset.
module tb_cp0_exception_ctrl;
    logic        clk = 1'b0;
    logic        rst, exception, eret, cp0_we;
    logic [31:0] cause_in, epc_in, cp0_wdata, cp0_rdata, redirect_pc;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic        pc_redirect, flush, exl;
    int          n_chk = 0;
    int          n_fail = 0;

    cp0_exception_ctrl dut (
        .clk(clk), .rst(rst), .exception(exception), .cause_in(cause_in), .epc_in(epc_in),
        .eret(eret), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .flush(flush), .exl(exl)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic redir(input string tag, input logic r, input logic [31:0] pc);
        chk({tag, "_redirect"}, {31'd0, pc_redirect}, {31'd0, r});
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, r});
        if (r) chk({tag, "_pc"}, redirect_pc, pc);
    endtask

    initial begin
        rst = 1'b1; exception = 1'b0; eret = 1'b0; cp0_we = 1'b0;
        cause_in = '0; epc_in = '0; cp0_wdata = '0; cp0_waddr = '0; cp0_raddr = '0;
        step(); step();
        rst = 1'b0;
        redir("rst", 1'b0, 32'h0);
        chk("rst_pc", redirect_pc, 32'h0);
        chk("rst_exl", {31'd0, exl}, 32'd0);
        rd("rst_status", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_cnt", 5'd9, 32'h0);

        // Overflow trap from RUN
        exception = 1'b1; cause_in = 32'd4; epc_in = 32'h40;
        step();
        exception = 1'b0;
        redir("ovf", 1'b1, 32'h180);
        chk("ovf_exl", {31'd0, exl}, 32'd1);
        rd("ovf_cause", 5'd13, 32'h430);
        rd("ovf_epc", 5'd14, 32'h40);
        rd("ovf_cnt", 5'd9, 32'h1);
        rd("ovf_status", 5'd12, 32'h2);
        rd("other_reg", 5'd3, 32'h0);
        step();
        redir("handler1", 1'b0, 32'h0);

        // Nested exception in HANDLER
        exception = 1'b1; cause_in = 32'd1; epc_in = 32'h184;
        step();
        exception = 1'b0;
        redir("nest", 1'b1, 32'h180);
        rd("nest_epc", 5'd14, 32'h40);
        rd("nest_cause", 5'd13, 32'h128);
        rd("nest_cnt", 5'd9, 32'h2);
        step();
        redir("handler2", 1'b0, 32'h0);

        // ERET back to EPC
        eret = 1'b1;
        step();
        eret = 1'b0;
        redir("eret", 1'b1, 32'h40);
        chk("eret_exl", {31'd0, exl}, 32'd0);
        step();
        redir("run1", 1'b0, 32'h0);

        // ERET in RUN ignored
        eret = 1'b1;
        step();
        eret = 1'b0;
        redir("eret_run", 1'b0, 32'h0);
        step();
        redir("eret_run2", 1'b0, 32'h0);

        // Exception with flag1, then simultaneous exception+eret in HANDLER
        exception = 1'b1; cause_in = 32'd2; epc_in = 32'h80;
        step();
        exception = 1'b0;
        rd("f1_cause", 5'd13, 32'h228);
        step();
        exception = 1'b1; eret = 1'b1; cause_in = 32'd4; epc_in = 32'h90;
        step();
        exception = 1'b0; eret = 1'b0;
        redir("simul", 1'b1, 32'h180);
        chk("simul_exl", {31'd0, exl}, 32'd1);
        rd("simul_epc", 5'd14, 32'h80);
        rd("simul_cnt", 5'd9, 32'h4);
        step();
        redir("simul_noret", 1'b0, 32'h0);

        // MTC0 EPC and read-only Cause in HANDLER
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h100;
        step();
        rd("mtc0_epc", 5'd14, 32'h100);
        cp0_waddr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
        step();
        cp0_we = 1'b0;
        rd("mtc0_cause_ro", 5'd13, 32'h430);
        eret = 1'b1;
        step();
        eret = 1'b0;
        redir("eret_mtc0", 1'b1, 32'h100);
        step();

        // MTC0 during TRAP dropped
        exception = 1'b1; cause_in = 32'd4; epc_in = 32'h200;
        step();
        exception = 1'b0;
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h999;
        step();
        cp0_we = 1'b0;
        rd("mtc0_trap_drop", 5'd14, 32'h200);
        eret = 1'b1;
        step();
        eret = 1'b0;
        redir("eret3", 1'b1, 32'h200);
        step();

        // MTC0 Status IE in RUN
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h1;
        step();
        cp0_we = 1'b0;
        rd("mtc0_status", 5'd12, 32'h1);
        chk("mtc0_status_exl", {31'd0, exl}, 32'd0);

        // Reset in TRAP cancels redirect
        exception = 1'b1; cause_in = 32'd4; epc_in = 32'h300;
        step();
        exception = 1'b0;
        redir("pre_rst", 1'b1, 32'h180);
        rst = 1'b1;
        step();
        rst = 1'b0;
        redir("rst_trap", 1'b0, 32'h0);
        chk("rst_trap_exl", {31'd0, exl}, 32'd0);
        step();
        redir("rst_trap2", 1'b0, 32'h0);
        rd("rst_trap_cnt", 5'd9, 32'h0);

        // ExcCount saturation
        for (int i = 0; i < 300; i++) begin
            exception = 1'b1; cause_in = 32'd1; epc_in = 32'h40;
            step();
            exception = 1'b0;
            step();
            eret = 1'b1;
            step();
            eret = 1'b0;
            step();
            if (i == 254) rd("cnt_255", 5'd9, 32'hFF);
        end
        rd("cnt_sat", 5'd9, 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
